// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent switch debouncers with edge and long-press pulses.
// Latency: a level first captured by the synchronizer at edge E reaches o_switch at edge E+DEBOUNCE_LIMIT+1.
// Backpressure: none; every output is a registered level or a single-cycle pulse.
//
// Ports:
//   i_clk     single rising-edge clock
//   i_rst_n   synchronous active-low reset
//   i_switch  raw asynchronous switch levels, one bit per channel
//   o_switch  debounced levels
//   o_rise    one-cycle pulse when a 0->1 change is accepted
//   o_fall    one-cycle pulse when a 1->0 change is accepted
//   o_hold    one-cycle pulse after the level has been high for HOLD_LIMIT cycles
//   o_any     OR of all o_rise/o_fall bits, aligned with them
module debounce_bank #(
  parameter int N_CH           = 4,
  parameter int DEBOUNCE_LIMIT = 315000,
  parameter int CNT_W          = 19,
  parameter int HOLD_LIMIT     = 25000000,
  parameter int HOLD_W         = 25
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_switch,
  output logic [N_CH-1:0] o_switch,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_hold,
  output logic            o_any
);

  localparam logic [CNT_W-1:0]  LP_CNT_MAX  = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] LP_HOLD_MAX = HOLD_W'(HOLD_LIMIT);
  localparam logic [HOLD_W-1:0] LP_HOLD_PRE = HOLD_W'(HOLD_LIMIT - 1);

  logic [N_CH-1:0]   r_s1;
  logic [N_CH-1:0]   r_s2;
  logic [CNT_W-1:0]  r_cnt  [N_CH];
  logic [HOLD_W-1:0] r_hold [N_CH];

  logic [CNT_W-1:0]  w_cnt_nxt  [N_CH];
  logic [HOLD_W-1:0] w_hold_nxt [N_CH];
  logic [N_CH-1:0]   w_sw_nxt;
  logic [N_CH-1:0]   w_hold_hit;
  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_fall;

  always_comb begin
    w_sw_nxt   = o_switch;
    w_hold_hit = '0;
    for (int n = 0; n < N_CH; n++) begin
      w_cnt_nxt[n]  = '0;
      w_hold_nxt[n] = '0;

      // Count consecutive mismatch cycles; any agreeing cycle leaves the
      // counter at its cleared default so the run must start over.
      if (r_s2[n] != o_switch[n]) begin
        if (r_cnt[n] == LP_CNT_MAX) begin
          w_sw_nxt[n] = r_s2[n];
        end else begin
          w_cnt_nxt[n] = r_cnt[n] + CNT_W'(1);
        end
      end

      // Hold counter runs on the current debounced level and saturates,
      // so the pre-limit value is seen only once per press.
      if (o_switch[n]) begin
        if (r_hold[n] != LP_HOLD_MAX) begin
          w_hold_nxt[n] = r_hold[n] + HOLD_W'(1);
        end else begin
          w_hold_nxt[n] = r_hold[n];
        end
        w_hold_hit[n] = (r_hold[n] == LP_HOLD_PRE);
      end
    end
    w_rise = w_sw_nxt & ~o_switch;
    w_fall = ~w_sw_nxt & o_switch;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      o_switch <= '0;
      o_rise   <= '0;
      o_fall   <= '0;
      o_hold   <= '0;
      o_any    <= 1'b0;
      for (int n = 0; n < N_CH; n++) begin
        r_cnt[n]  <= '0;
        r_hold[n] <= '0;
      end
    end else begin
      r_s1     <= i_switch;
      r_s2     <= r_s1;
      o_switch <= w_sw_nxt;
      o_rise   <= w_rise;
      o_fall   <= w_fall;
      o_hold   <= w_hold_hit;
      o_any    <= |(w_rise | w_fall);
      for (int n = 0; n < N_CH; n++) begin
        r_cnt[n]  <= w_cnt_nxt[n];
        r_hold[n] <= w_hold_nxt[n];
      end
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus randomized toggling against a behavioural model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: not applicable.
module tb_debounce_bank;

  localparam int NCH = 4;
  localparam int DL  = 4;
  localparam int HL  = 10;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] o_switch;
  logic [NCH-1:0] o_rise;
  logic [NCH-1:0] o_fall;
  logic [NCH-1:0] o_hold;
  logic           o_any;

  debounce_bank #(
    .N_CH          (NCH),
    .DEBOUNCE_LIMIT(DL),
    .CNT_W         (3),
    .HOLD_LIMIT    (HL),
    .HOLD_W        (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_switch(sw),
    .o_switch(o_switch),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_hold  (o_hold),
    .o_any   (o_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: two-sample delay line, length of the current
  // disagreement run, accepted level, and edge number of the last rise.
  logic [NCH-1:0] m_s1    = '0;
  logic [NCH-1:0] m_s2    = '0;
  logic [NCH-1:0] m_level = '0;
  int             m_run    [NCH];
  int             m_rise_t [NCH];
  logic [NCH-1:0] e_rise, e_fall, e_hold;
  logic           e_any;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic step();
    logic [NCH-1:0] prev;
    @(posedge clk);
    cyc++;
    prev   = m_level;
    e_rise = '0;
    e_fall = '0;
    e_hold = '0;
    if (!rst_n) begin
      m_s1    = '0;
      m_s2    = '0;
      m_level = '0;
      for (int c = 0; c < NCH; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (m_s2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DL) begin
            m_level[c] = m_s2[c];
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        e_hold[c] = prev[c] && ((cyc - m_rise_t[c]) == HL);
      end
      e_rise = m_level & ~prev;
      e_fall = ~m_level & prev;
      for (int c = 0; c < NCH; c++) if (e_rise[c]) m_rise_t[c] = cyc;
      m_s2 = m_s1;
      m_s1 = sw;
    end
    e_any = |(e_rise | e_fall);
    #1;
    chk("m_switch", 8'(o_switch), 8'(m_level));
    chk("m_rise",   8'(o_rise),   8'(e_rise));
    chk("m_fall",   8'(o_fall),   8'(e_fall));
    chk("m_hold",   8'(o_hold),   8'(e_hold));
    chk("m_any",    8'(o_any),    8'(e_any));
  endtask

  initial begin
    int k;
    int any_cnt;
    int p;
    int plist [5];
    plist = '{2, 3, 6, 12, 40};
    for (int c = 0; c < NCH; c++) begin
      m_run[c]    = 0;
      m_rise_t[c] = -1000;
    end

    // Reset state
    sw    = '0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_switch", 8'(o_switch), 8'h00);
    chk("rst_pulses", 8'({o_rise, o_fall}), 8'h00);
    chk("rst_any",    8'(o_any),    8'h00);
    rst_n = 1'b1;
    repeat (4) step();

    // Clean press on ch0: accepted five edges after first sampling edge
    sw = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("p0_rise", 8'(o_rise), (i == 6) ? 8'h01 : 8'h00);
    end
    chk("p0_switch", 8'(o_switch), 8'h01);
    chk("p0_any",    8'(o_any),    8'h01);
    step();
    chk("p0_rise_once", 8'(o_rise), 8'h00);

    // Bounce on ch1: 1,1,1,0 then steady 1
    sw[1] = 1'b1;
    repeat (3) step();
    sw[1] = 1'b0;
    step();
    chk("b1_no_change", 8'(o_switch[1]), 8'h00);
    sw[1] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("b1_switch", 8'(o_switch[1]), (i == 6) ? 8'h01 : 8'h00);
    end

    // Long press on ch2
    sw = '0;
    repeat (10) step();
    sw[2] = 1'b1;
    k = 0;
    while (o_rise[2] !== 1'b1 && k < 15) begin
      step();
      k++;
    end
    chk("h2_rise_seen", 8'(o_rise[2]), 8'h01);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("h2_hold", 8'(o_hold[2]), (i == 10) ? 8'h01 : 8'h00);
    end

    // Short press on ch2: release before the hold limit
    sw[2] = 1'b0;
    repeat (8) step();
    sw[2] = 1'b1;
    k = 0;
    while (o_rise[2] !== 1'b1 && k < 15) begin
      step();
      k++;
    end
    chk("s2_rise_seen", 8'(o_rise[2]), 8'h01);
    sw[2] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("s2_no_hold", 8'(o_hold[2]), 8'h00);
      chk("s2_fall",    8'(o_fall[2]), (i == 6) ? 8'h01 : 8'h00);
    end

    // All channels pressed together
    sw = '0;
    repeat (10) step();
    sw = 4'b1111;
    any_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 6) chk("all_rise", 8'(o_rise), 8'h0F);
      any_cnt += int'(o_any);
    end
    chk("all_any_once", 8'(any_cnt), 8'h01);

    // Reset mid-count on ch3, then re-detect the held level
    sw = '0;
    repeat (14) step();
    sw[3] = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("r3_switch", 8'(o_switch), 8'h00);
    chk("r3_pulses", 8'({o_rise, o_fall}), 8'h00);
    chk("r3_hold",   8'(o_hold),   8'h00);
    chk("r3_any",    8'(o_any),    8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("r3_rise", 8'(o_rise), (i == 6) ? 8'h08 : 8'h00);
    end

    // Randomized toggling with varying bounce density and rare resets
    for (int seg = 0; seg < 12; seg++) begin
      p = plist[$urandom_range(4)];
      for (int i = 0; i < 60; i++) begin
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(p - 1) == 0) sw[c] = ~sw[c];
        end
        rst_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
